// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - DRAM arbiter for instruction/data line fills and write-back drain
//
// Purpose: shares a single-outstanding DRAM command port between an instruction
// line-fill requester, a data line-fill requester and a write-back FIFO. Reads
// alternate on ties; the write-back FIFO is forced through after it has been
// passed over WB_STARVE_LIMIT times in a row.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   prog_req/prog_addr               instruction line-fill request (64-byte line address)
//   data_req/data_addr               data line-fill request (64-byte line address)
//   prog_grant, data_grant           pulse when the DRAM accepts that requester's read
//   prog_fill_valid, data_fill_valid pulse when the returned line is available
//   prog_fill_data, data_fill_data   returned line, held until the next fill
//   wb_empty/wb_addr/wb_data         write-back FIFO head
//   wb_pop                           pulse when the FIFO head has been consumed
//   dram_cmd_*                       DRAM command valid/ready handshake and fields
//   dram_rsp_valid/dram_rsp_data     DRAM read response, one beat per read
//   busy                             any transaction in flight
//   rsp_err                          sticky: response arrived when none was expected
module mem_arbiter #(
  parameter int WB_STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         prog_req,
  input  logic [17:0]  prog_addr,
  input  logic         data_req,
  input  logic [17:0]  data_addr,
  output logic         prog_grant,
  output logic         data_grant,
  output logic         prog_fill_valid,
  output logic         data_fill_valid,
  output logic [511:0] prog_fill_data,
  output logic [511:0] data_fill_data,
  input  logic         wb_empty,
  input  logic [31:0]  wb_addr,
  input  logic [31:0]  wb_data,
  output logic         wb_pop,
  output logic         dram_cmd_valid,
  input  logic         dram_cmd_ready,
  output logic         dram_cmd_we,
  output logic [31:0]  dram_cmd_addr,
  output logic [31:0]  dram_cmd_wdata,
  input  logic         dram_rsp_valid,
  input  logic [511:0] dram_rsp_data,
  output logic         busy,
  output logic         rsp_err
);

  localparam int            SW         = $clog2(WB_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(WB_STARVE_LIMIT);
  localparam logic          OWN_PROG   = 1'b0;
  localparam logic          OWN_DATA   = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE_RD, WAIT_RSP, ISSUE_WR} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_rd_q, last_rd_d;
  logic [SW-1:0]  starve_cnt_q, starve_cnt_d;
  logic           cmd_we_q, cmd_we_d;
  logic [31:0]    cmd_addr_q, cmd_addr_d;
  logic [31:0]    cmd_wdata_q, cmd_wdata_d;
  logic [511:0]   prog_fill_data_q, prog_fill_data_d;
  logic [511:0]   data_fill_data_q, data_fill_data_d;
  logic           prog_fill_valid_q, prog_fill_valid_d;
  logic           data_fill_valid_q, data_fill_valid_d;
  logic           rsp_err_q, rsp_err_d;

  logic           rd_any;
  logic           wb_avail;
  logic           pick_data;
  logic [17:0]    rd_addr;

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_rd_d         = last_rd_q;
    starve_cnt_d      = starve_cnt_q;
    cmd_we_d          = cmd_we_q;
    cmd_addr_d        = cmd_addr_q;
    cmd_wdata_d       = cmd_wdata_q;
    prog_fill_data_d  = prog_fill_data_q;
    data_fill_data_d  = data_fill_data_q;
    prog_fill_valid_d = 1'b0;
    data_fill_valid_d = 1'b0;
    prog_grant        = 1'b0;
    data_grant        = 1'b0;
    wb_pop            = 1'b0;

    // A stray response is dropped; only the error flag records it.
    rsp_err_d = rsp_err_q | (dram_rsp_valid && (state_q != WAIT_RSP));

    rd_any   = prog_req | data_req;
    wb_avail = !wb_empty;
    // On a tie, serve whichever requester was not granted last.
    pick_data = (prog_req && data_req) ? (last_rd_q == OWN_PROG) : data_req;
    rd_addr   = pick_data ? data_addr : prog_addr;

    if (wb_empty) begin
      starve_cnt_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (wb_avail && (!rd_any || (starve_cnt_q >= STARVE_MAX))) begin
          cmd_we_d     = 1'b1;
          cmd_addr_d   = wb_addr;
          cmd_wdata_d  = wb_data;
          starve_cnt_d = '0;
          state_d      = ISSUE_WR;
        end else if (rd_any) begin
          owner_d    = pick_data;
          cmd_we_d   = 1'b0;
          cmd_addr_d = {8'b0, rd_addr, 6'b0};
          state_d    = ISSUE_RD;
          if (wb_avail && (starve_cnt_q < STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end
        end
      end
      ISSUE_RD: begin
        if (dram_cmd_ready) begin
          prog_grant = (owner_q == OWN_PROG);
          data_grant = (owner_q == OWN_DATA);
          last_rd_d  = owner_q;
          state_d    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dram_rsp_valid) begin
          if (owner_q == OWN_DATA) begin
            data_fill_data_d  = dram_rsp_data;
            data_fill_valid_d = 1'b1;
          end else begin
            prog_fill_data_d  = dram_rsp_data;
            prog_fill_valid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      ISSUE_WR: begin
        if (dram_cmd_ready) begin
          wb_pop  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      owner_q           <= OWN_PROG;
      last_rd_q         <= OWN_PROG;
      starve_cnt_q      <= '0;
      cmd_we_q          <= 1'b0;
      cmd_addr_q        <= '0;
      cmd_wdata_q       <= '0;
      prog_fill_data_q  <= '0;
      data_fill_data_q  <= '0;
      prog_fill_valid_q <= 1'b0;
      data_fill_valid_q <= 1'b0;
      rsp_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      last_rd_q         <= last_rd_d;
      starve_cnt_q      <= starve_cnt_d;
      cmd_we_q          <= cmd_we_d;
      cmd_addr_q        <= cmd_addr_d;
      cmd_wdata_q       <= cmd_wdata_d;
      prog_fill_data_q  <= prog_fill_data_d;
      data_fill_data_q  <= data_fill_data_d;
      prog_fill_valid_q <= prog_fill_valid_d;
      data_fill_valid_q <= data_fill_valid_d;
      rsp_err_q         <= rsp_err_d;
    end
  end

  assign dram_cmd_valid  = (state_q == ISSUE_RD) || (state_q == ISSUE_WR);
  assign dram_cmd_we     = cmd_we_q;
  assign dram_cmd_addr   = cmd_addr_q;
  assign dram_cmd_wdata  = cmd_wdata_q;
  assign prog_fill_data  = prog_fill_data_q;
  assign data_fill_data  = data_fill_data_q;
  assign prog_fill_valid = prog_fill_valid_q;
  assign data_fill_valid = data_fill_valid_q;
  assign busy            = (state_q != IDLE);
  assign rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         prog_req, data_req;
  logic [17:0]  prog_addr, data_addr;
  logic         prog_grant, data_grant;
  logic         prog_fill_valid, data_fill_valid;
  logic [511:0] prog_fill_data, data_fill_data;
  logic         wb_empty;
  logic [31:0]  wb_addr, wb_data;
  logic         wb_pop;
  logic         dram_cmd_valid, dram_cmd_ready, dram_cmd_we;
  logic [31:0]  dram_cmd_addr, dram_cmd_wdata;
  logic         dram_rsp_valid;
  logic [511:0] dram_rsp_data;
  logic         busy, rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int pg_cnt = 0, dg_cnt = 0, pf_cnt = 0, df_cnt = 0, pop_cnt = 0;

  mem_arbiter #(.WB_STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .prog_req(prog_req), .prog_addr(prog_addr),
    .data_req(data_req), .data_addr(data_addr),
    .prog_grant(prog_grant), .data_grant(data_grant),
    .prog_fill_valid(prog_fill_valid), .data_fill_valid(data_fill_valid),
    .prog_fill_data(prog_fill_data), .data_fill_data(data_fill_data),
    .wb_empty(wb_empty), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pop(wb_pop),
    .dram_cmd_valid(dram_cmd_valid), .dram_cmd_ready(dram_cmd_ready),
    .dram_cmd_we(dram_cmd_we), .dram_cmd_addr(dram_cmd_addr),
    .dram_cmd_wdata(dram_cmd_wdata),
    .dram_rsp_valid(dram_rsp_valid), .dram_rsp_data(dram_rsp_data),
    .busy(busy), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (prog_grant)      pg_cnt  <= pg_cnt + 1;
    if (data_grant)      dg_cnt  <= dg_cnt + 1;
    if (prog_fill_valid) pf_cnt  <= pf_cnt + 1;
    if (data_fill_valid) df_cnt  <= df_cnt + 1;
    if (wb_pop)          pop_cnt <= pop_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays the DRAM side of one transaction: holds ready low for rdy_dly cycles
  // of valid, accepts, then (for reads) returns rdata rsp_dly cycles after the
  // accept. Returns at mid-cycle of the fill cycle for reads.
  task automatic serve(input int rdy_dly, input int rsp_dly, input logic exp_we,
                       input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [511:0] rdata);
    int n = 0;
    @(negedge clk);
    while (!dram_cmd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_valid", dram_cmd_valid, 1'b1);
    check("cmd_we", dram_cmd_we, exp_we);
    check("cmd_addr", dram_cmd_addr, exp_addr);
    if (exp_we) check("cmd_wdata", dram_cmd_wdata, exp_wdata);
    check("no_grant_unready", prog_grant | data_grant | wb_pop, 1'b0);
    for (int i = 1; i < rdy_dly; i++) begin
      @(negedge clk);
      check("hold_valid", dram_cmd_valid, 1'b1);
      check("hold_addr", dram_cmd_addr, exp_addr);
      check("hold_no_grant", prog_grant | data_grant | wb_pop, 1'b0);
    end
    @(posedge clk); #1;
    dram_cmd_ready = 1'b1;
    @(negedge clk);
    check("accept_pulse", prog_grant | data_grant | wb_pop, 1'b1);
    @(posedge clk); #1;
    dram_cmd_ready = 1'b0;
    if (exp_we) begin
      wb_empty = 1'b1;
    end else begin
      check("wait_rsp_busy", busy, 1'b1);
      check("wait_rsp_no_cmd", dram_cmd_valid, 1'b0);
      repeat (rsp_dly - 1) @(posedge clk);
      #1;
      dram_rsp_valid = 1'b1;
      dram_rsp_data  = rdata;
      @(posedge clk); #1;
      dram_rsp_valid = 1'b0;
      dram_rsp_data  = '0;
      @(negedge clk);
    end
  endtask

  int           pg0, dg0, pf0, df0, pop0;
  logic [511:0] dd;

  task automatic snap();
    pg0 = pg_cnt; dg0 = dg_cnt; pf0 = pf_cnt; df0 = df_cnt; pop0 = pop_cnt;
  endtask

  initial begin
    reset = 1'b1;
    prog_req = 1'b0; data_req = 1'b0; prog_addr = '0; data_addr = '0;
    wb_empty = 1'b1; wb_addr = '0; wb_data = '0;
    dram_cmd_ready = 1'b0; dram_rsp_valid = 1'b0; dram_rsp_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_valid", dram_cmd_valid, 1'b0);
    check("rst_cmd_fields", {dram_cmd_we, dram_cmd_addr, dram_cmd_wdata}, 65'd0);
    check("rst_fill_data", {prog_fill_data, data_fill_data}, '0);
    check("rst_pulses", {prog_grant, data_grant, prog_fill_valid, data_fill_valid, wb_pop}, 5'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    reset = 1'b0;

    // Single instruction fill, response 4 cycles after accept
    snap();
    @(posedge clk); #1;
    prog_req = 1'b1; prog_addr = 18'h00003;
    serve(1, 4, 1'b0, 32'h000000C0, 32'h0, {64{8'hA5}});
    check("t1_fill_valid", prog_fill_valid, 1'b1);
    check("t1_fill_data", prog_fill_data, {64{8'hA5}});
    check("t1_busy_idle", busy, 1'b0);
    prog_req = 1'b0;
    @(negedge clk);
    check("t1_fill_pulse_end", prog_fill_valid, 1'b0);
    check("t1_fill_data_held", prog_fill_data, {64{8'hA5}});
    repeat (2) @(negedge clk);
    check("t1_pg_once", pg_cnt - pg0, 1);
    check("t1_pf_once", pf_cnt - pf0, 1);
    check("t1_data_silent", (dg_cnt - dg0) + (df_cnt - df0), 0);

    // Both requesters: data wins the first tie, then prog
    snap();
    @(posedge clk); #1;
    prog_req = 1'b1; prog_addr = 18'h00010;
    data_req = 1'b1; data_addr = 18'h00020;
    serve(1, 2, 1'b0, 32'h00000800, 32'h0, {16{32'hDDDD0001}});
    check("t2_data_fill_valid", data_fill_valid, 1'b1);
    check("t2_data_fill_data", data_fill_data, {16{32'hDDDD0001}});
    check("t2_prog_not_yet", pg_cnt - pg0, 0);
    data_req = 1'b0;
    serve(1, 3, 1'b0, 32'h00000400, 32'h0, {16{32'hEEEE0002}});
    check("t2_prog_fill_valid", prog_fill_valid, 1'b1);
    check("t2_prog_fill_data", prog_fill_data, {16{32'hEEEE0002}});
    prog_req = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_pg_once", pg_cnt - pg0, 1);
    check("t2_dg_once", dg_cnt - dg0, 1);

    // Write-back starvation: 8 read selections, then the write is forced
    snap();
    @(posedge clk); #1;
    wb_empty = 1'b0; wb_addr = 32'hDEAD0040; wb_data = 32'h12345678;
    data_req = 1'b1; data_addr = 18'h00020;
    for (int i = 0; i < 8; i++) begin
      dd = {16{32'hD0000000 + 32'(i)}};
      serve(1, 2, 1'b0, 32'h00000800, 32'h0, dd);
      check("t3_fill_valid", data_fill_valid, 1'b1);
      check("t3_fill_data", data_fill_data, dd);
    end
    serve(1, 1, 1'b1, 32'hDEAD0040, 32'h12345678, '0);
    serve(1, 1, 1'b0, 32'h00000800, 32'h0, {16{32'hCAFE0009}});
    check("t3_last_fill", data_fill_data, {16{32'hCAFE0009}});
    data_req = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_pop_once", pop_cnt - pop0, 1);
    check("t3_dg_count", dg_cnt - dg0, 9);
    check("t3_df_count", df_cnt - df0, 9);

    // Ready held low 5 cycles while the read command is presented
    snap();
    @(posedge clk); #1;
    prog_req = 1'b1; prog_addr = 18'h3FFFF;
    serve(5, 2, 1'b0, 32'h00FFFFC0, 32'h0, {16{32'h5A5A5A5A}});
    check("t4_fill_data", prog_fill_data, {16{32'h5A5A5A5A}});
    prog_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_pg_once", pg_cnt - pg0, 1);

    // Stray response in IDLE
    snap();
    @(posedge clk); #1;
    dram_rsp_valid = 1'b1; dram_rsp_data = {16{32'hBADBAD00}};
    @(posedge clk); #1;
    dram_rsp_valid = 1'b0; dram_rsp_data = '0;
    @(negedge clk);
    check("t5_rsp_err", rsp_err, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_prog_data_kept", prog_fill_data, {16{32'h5A5A5A5A}});
    check("t5_data_data_kept", data_fill_data, {16{32'hCAFE0009}});
    repeat (3) @(negedge clk);
    check("t5_rsp_err_sticky", rsp_err, 1'b1);
    check("t5_no_fill", (pf_cnt - pf0) + (df_cnt - df0), 0);

    // Reset while waiting for a response
    snap();
    @(posedge clk); #1;
    prog_req = 1'b1; prog_addr = 18'h00005; dram_cmd_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dram_cmd_ready = 1'b0; prog_req = 1'b0;
    @(negedge clk);
    check("t6_in_wait", busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_err", rsp_err, 1'b0);
    check("t6_async_fill", prog_fill_data, '0);
    check("t6_async_cmd", {dram_cmd_valid, dram_cmd_addr}, 33'd0);
    @(posedge clk); #1;
    dram_rsp_valid = 1'b1; dram_rsp_data = {16{32'h0BAD0BAD}};
    @(posedge clk); #1;
    dram_rsp_valid = 1'b0; dram_rsp_data = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_err_after_rst", rsp_err, 1'b0);
    @(posedge clk); #1;
    dram_rsp_valid = 1'b1; dram_rsp_data = {16{32'h0BAD0BAD}};
    @(posedge clk); #1;
    dram_rsp_valid = 1'b0; dram_rsp_data = '0;
    @(negedge clk);
    check("t6_err_late_rsp", rsp_err, 1'b1);
    check("t6_fill_data_zero", prog_fill_data, '0);
    repeat (2) @(negedge clk);
    check("t6_pg_before_rst", pg_cnt - pg0, 1);
    check("t6_no_fill", pf_cnt - pf0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
